// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the PC generation stage.
//   pc_state_e           - PC generator FSM state (BOOT / RUN / HALT)
//   INSTR_BYTES          - byte increment for a 32-bit instruction
//   RVC_BYTES            - byte increment for a 16-bit compressed instruction
//   DEFAULT_RESET_VECTOR - PC loaded on reset unless overridden by parameter
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [63:0] INSTR_BYTES          = 64'd4;
  localparam logic [63:0] RVC_BYTES            = 64'd2;
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pc_align_check.sv
// pc_align_check: combinational alignment test on a redirect target.
// Configuration macro: PCGEN_RVC_EN
//   defined   - halfword alignment (only bit [0] must be zero)
//   undefined - word alignment (bits [1:0] must be zero)
// Ports:
//   target_lsb  in  [1:0]  low two bits of the candidate target
//   misaligned  out        target violates the alignment rule
module pc_align_check (
  input  logic [1:0] target_lsb,
  output logic       misaligned
);

`ifdef PCGEN_RVC_EN
  // Bit 1 is a legal halfword offset with compressed instructions.
  logic unused_lsb1;
  assign unused_lsb1 = target_lsb[1];
  assign misaligned  = target_lsb[0];
`else
  assign misaligned  = |target_lsb;
`endif

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generation stage feeding the fetch stage.
// Holds the fetch PC, advances it sequentially and applies redirects with
// priority trap > branch > stall > sequential. A misaligned branch target
// raises misaligned_o and parks the stage in HALT until a trap arrives.
// Configuration macro: PCGEN_RVC_EN (compressed-instruction support).
// Ports:
//   clk                 in       rising-edge clock
//   reset               in       asynchronous active-high reset
//   stall_i             in       hold the PC
//   branch_taken_i      in       branch/jump resolved taken
//   branch_target_i     in  [63:0] branch/jump target
//   trap_i              in       trap/return redirect
//   trap_target_i       in  [63:0] trap target
//   instr_compressed_i  in       current instruction is 16-bit (RVC only)
//   pc_o                out [63:0] fetch PC
//   pc_valid_o          out      pc_o is a valid fetch address (state RUN)
//   redirect_o          out      one-cycle pulse on every redirect
//   misaligned_o        out      one-cycle pulse on a misaligned target
//   misaligned_addr_o   out [63:0] last offending target
//   state_o             out      current FSM state (debug observation)
// Handshake note: there is no valid/ready pair here; stall_i is a level
// hold that is overridden by any redirect in the same cycle.
module pc_gen
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [63:0] branch_target_i,
  input  logic        trap_i,
  input  logic [63:0] trap_target_i,
  input  logic        instr_compressed_i,
  output logic [63:0] pc_o,
  output logic        pc_valid_o,
  output logic        redirect_o,
  output logic        misaligned_o,
  output logic [63:0] misaligned_addr_o,
  output pc_state_e   state_o
);

  pc_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        mis_q, mis_d;
  logic [63:0] mis_addr_q, mis_addr_d;

  logic        branch_misaligned;
  logic [63:0] trap_pc;
  logic [63:0] pc_incr;

  pc_align_check u_align (
    .target_lsb (branch_target_i[1:0]),
    .misaligned (branch_misaligned)
  );

`ifdef PCGEN_RVC_EN
  assign trap_pc = {trap_target_i[63:1], 1'b0};
  assign pc_incr = instr_compressed_i ? RVC_BYTES : INSTR_BYTES;
`else
  logic unused_compressed;
  assign unused_compressed = instr_compressed_i;
  assign trap_pc = {trap_target_i[63:2], 2'b00};
  assign pc_incr = INSTR_BYTES;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // A trap in the same cycle drops the branch, misaligned or not.
        if (!trap_i && branch_taken_i && branch_misaligned) state_d = HALT;
      end
      HALT: begin
        if (trap_i) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Datapath / output logic: values registered on the next edge.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    case (state_q)
      RUN: begin
        if (trap_i) begin
          pc_d       = trap_pc;
          redirect_d = 1'b1;
        end else if (branch_taken_i) begin
          if (branch_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = branch_target_i;
          end else begin
            pc_d       = branch_target_i;
            redirect_d = 1'b1;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + pc_incr; // wraps modulo 2^64
        end
      end
      HALT: begin
        if (trap_i) begin
          pc_d       = trap_pc;
          redirect_d = 1'b1;
        end
      end
      default: ; // BOOT holds everything
    endcase
  end

  assign pc_o              = pc_q;
  assign pc_valid_o        = (state_q == RUN);
  assign redirect_o        = redirect_q;
  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = mis_addr_q;
  assign state_o           = state_q;

endmodule
